// File: rtl/vxe_txn_codec_pkg.sv
// ============================================================================
// Module  : vxe_txn_codec_pkg
// Purpose : Field widths and vector slice positions for the txn codec.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package vxe_txn_codec_pkg;

  localparam int TXNID_W = 6;
  localparam int ADDR_W  = 37;
  localparam int DATA_W  = 64;
  localparam int BEN_W   = 8;
  localparam int ERR_W   = 2;

  localparam int REQ_TXN_W = TXNID_W + 1 + ADDR_W;  // 44
  localparam int REQ_DAT_W = DATA_W + BEN_W;        // 72
  localparam int RES_TXN_W = TXNID_W + 1 + ERR_W;   // 9
  localparam int RES_DAT_W = DATA_W;                // 64

  localparam int RQ_TXNID_MSB = 43;
  localparam int RQ_TXNID_LSB = 38;
  localparam int RQ_RNW_BIT   = 37;
  localparam int RQ_ADDR_MSB  = 36;
  localparam int RQ_ADDR_LSB  = 0;
  localparam int RQ_DATA_MSB  = 71;
  localparam int RQ_DATA_LSB  = 8;
  localparam int RQ_BEN_MSB   = 7;
  localparam int RQ_BEN_LSB   = 0;

  localparam int RS_TXNID_MSB = 8;
  localparam int RS_TXNID_LSB = 3;
  localparam int RS_RNW_BIT   = 2;
  localparam int RS_ERR_MSB   = 1;
  localparam int RS_ERR_LSB   = 0;

  typedef logic [REQ_TXN_W-1:0] req_txn_t;
  typedef logic [REQ_DAT_W-1:0] req_dat_t;
  typedef logic [RES_TXN_W-1:0] res_txn_t;
  typedef logic [RES_DAT_W-1:0] res_dat_t;

endpackage

`default_nettype wire

// File: rtl/vxe_txn_codec_leaves.sv
// ============================================================================
// Modules : vxe_txnreq_coder / vxe_txnreq_decoder / vxe_txnres_coder /
//           vxe_txnres_decoder -- combinational field <-> vector slicing.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module vxe_txnreq_coder
  import vxe_txn_codec_pkg::*;
(
  input  logic [TXNID_W-1:0] i_txnid,
  input  logic               i_rnw,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [DATA_W-1:0]  i_data,
  input  logic [BEN_W-1:0]   i_ben,
  output req_txn_t           o_vec_txn,
  output req_dat_t           o_vec_dat
);
  assign o_vec_txn = {i_txnid, i_rnw, i_addr};
  assign o_vec_dat = {i_data, i_ben};
endmodule

module vxe_txnreq_decoder
  import vxe_txn_codec_pkg::*;
(
  input  req_txn_t           i_vec_txn,
  input  req_dat_t           i_vec_dat,
  output logic [TXNID_W-1:0] o_txnid,
  output logic               o_rnw,
  output logic [ADDR_W-1:0]  o_addr,
  output logic [DATA_W-1:0]  o_data,
  output logic [BEN_W-1:0]   o_ben
);
  assign o_txnid = i_vec_txn[RQ_TXNID_MSB:RQ_TXNID_LSB];
  assign o_rnw   = i_vec_txn[RQ_RNW_BIT];
  assign o_addr  = i_vec_txn[RQ_ADDR_MSB:RQ_ADDR_LSB];
  assign o_data  = i_vec_dat[RQ_DATA_MSB:RQ_DATA_LSB];
  assign o_ben   = i_vec_dat[RQ_BEN_MSB:RQ_BEN_LSB];
endmodule

module vxe_txnres_coder
  import vxe_txn_codec_pkg::*;
(
  input  logic [TXNID_W-1:0] i_txnid,
  input  logic               i_rnw,
  input  logic [ERR_W-1:0]   i_err,
  input  logic [DATA_W-1:0]  i_data,
  output res_txn_t           o_vec_txn,
  output res_dat_t           o_vec_dat
);
  assign o_vec_txn = {i_txnid, i_rnw, i_err};
  assign o_vec_dat = i_data;
endmodule

// Response inverse, for consumers on the far side of the response channel.
module vxe_txnres_decoder
  import vxe_txn_codec_pkg::*;
(
  input  res_txn_t           i_vec_txn,
  input  res_dat_t           i_vec_dat,
  output logic [TXNID_W-1:0] o_txnid,
  output logic               o_rnw,
  output logic [ERR_W-1:0]   o_err,
  output logic [DATA_W-1:0]  o_data
);
  assign o_txnid = i_vec_txn[RS_TXNID_MSB:RS_TXNID_LSB];
  assign o_rnw   = i_vec_txn[RS_RNW_BIT];
  assign o_err   = i_vec_txn[RS_ERR_MSB:RS_ERR_LSB];
  assign o_data  = i_vec_dat;
endmodule

`default_nettype wire

// File: rtl/vxe_txn_codec.sv
// ============================================================================
// Module  : vxe_txn_codec -- valid-qualified registered request/response
//           coding with combinational loopback decode of the request vectors.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module vxe_txn_codec
  import vxe_txn_codec_pkg::*;
(
  input  logic               clk,
  input  logic               nrst,
  input  logic               i_rq_vld,
  input  logic [TXNID_W-1:0] i_txnid_rq,
  input  logic               i_rnw_rq,
  input  logic [ADDR_W-1:0]  i_addr_rq,
  input  logic [DATA_W-1:0]  i_data_rq,
  input  logic [BEN_W-1:0]   i_ben_rq,
  output logic               o_rq_vld,
  output req_txn_t           o_req_vec_txn,
  output req_dat_t           o_req_vec_dat,
  output logic [TXNID_W-1:0] o_txnid_rq,
  output logic               o_rnw_rq,
  output logic [ADDR_W-1:0]  o_addr_rq,
  output logic [DATA_W-1:0]  o_data_rq,
  output logic [BEN_W-1:0]   o_ben_rq,
  input  logic               i_rs_vld,
  input  logic [TXNID_W-1:0] i_txnid_rs,
  input  logic               i_rnw_rs,
  input  logic [ERR_W-1:0]   i_err_rs,
  input  logic [DATA_W-1:0]  i_data_rs,
  output logic               o_rs_vld,
  output res_txn_t           o_res_vec_txn,
  output res_dat_t           o_res_vec_dat
);

  req_txn_t w_req_vec_txn;
  req_dat_t w_req_vec_dat;
  res_txn_t w_res_vec_txn;
  res_dat_t w_res_vec_dat;

  logic     r_rq_vld;
  req_txn_t r_req_vec_txn;
  req_dat_t r_req_vec_dat;
  logic     r_rs_vld;
  res_txn_t r_res_vec_txn;
  res_dat_t r_res_vec_dat;

  vxe_txnreq_coder u_req_coder (
    .i_txnid   (i_txnid_rq),
    .i_rnw     (i_rnw_rq),
    .i_addr    (i_addr_rq),
    .i_data    (i_data_rq),
    .i_ben     (i_ben_rq),
    .o_vec_txn (w_req_vec_txn),
    .o_vec_dat (w_req_vec_dat)
  );

  vxe_txnres_coder u_res_coder (
    .i_txnid   (i_txnid_rs),
    .i_rnw     (i_rnw_rs),
    .i_err     (i_err_rs),
    .i_data    (i_data_rs),
    .o_vec_txn (w_res_vec_txn),
    .o_vec_dat (w_res_vec_dat)
  );

  // Vectors load only on a valid beat and otherwise hold; valids follow every cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rq_vld      <= 1'b0;
      r_req_vec_txn <= '0;
      r_req_vec_dat <= '0;
      r_rs_vld      <= 1'b0;
      r_res_vec_txn <= '0;
      r_res_vec_dat <= '0;
    end else begin
      r_rq_vld <= i_rq_vld;
      r_rs_vld <= i_rs_vld;
      if (i_rq_vld) begin
        r_req_vec_txn <= w_req_vec_txn;
        r_req_vec_dat <= w_req_vec_dat;
      end
      if (i_rs_vld) begin
        r_res_vec_txn <= w_res_vec_txn;
        r_res_vec_dat <= w_res_vec_dat;
      end
    end
  end

  vxe_txnreq_decoder u_req_loopback (
    .i_vec_txn (r_req_vec_txn),
    .i_vec_dat (r_req_vec_dat),
    .o_txnid   (o_txnid_rq),
    .o_rnw     (o_rnw_rq),
    .o_addr    (o_addr_rq),
    .o_data    (o_data_rq),
    .o_ben     (o_ben_rq)
  );

  assign o_rq_vld      = r_rq_vld;
  assign o_req_vec_txn = r_req_vec_txn;
  assign o_req_vec_dat = r_req_vec_dat;
  assign o_rs_vld      = r_rs_vld;
  assign o_res_vec_txn = r_res_vec_txn;
  assign o_res_vec_dat = r_res_vec_dat;

endmodule

`default_nettype wire

// File: tb/tb_vxe_txn_codec.sv
// ============================================================================
// Module  : tb_vxe_txn_codec -- table-driven scoreboard bench for vxe_txn_codec.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vxe_txn_codec;
  import vxe_txn_codec_pkg::*;

  logic        clk = 1'b0;
  logic        nrst;
  logic        i_rq_vld, i_rnw_rq, i_rs_vld, i_rnw_rs;
  logic [5:0]  i_txnid_rq, i_txnid_rs;
  logic [36:0] i_addr_rq;
  logic [63:0] i_data_rq, i_data_rs;
  logic [7:0]  i_ben_rq;
  logic [1:0]  i_err_rs;
  logic        o_rq_vld, o_rnw_rq, o_rs_vld;
  logic [43:0] o_req_vec_txn;
  logic [71:0] o_req_vec_dat;
  logic [5:0]  o_txnid_rq;
  logic [36:0] o_addr_rq;
  logic [63:0] o_data_rq;
  logic [7:0]  o_ben_rq;
  logic [8:0]  o_res_vec_txn;
  logic [63:0] o_res_vec_dat;
  logic [5:0]  w_dtxnid_rs;
  logic        w_drnw_rs;
  logic [1:0]  w_derr_rs;
  logic [63:0] w_ddata_rs;

  always #5 clk = ~clk;

  vxe_txn_codec dut (
    .clk(clk), .nrst(nrst),
    .i_rq_vld(i_rq_vld), .i_txnid_rq(i_txnid_rq), .i_rnw_rq(i_rnw_rq),
    .i_addr_rq(i_addr_rq), .i_data_rq(i_data_rq), .i_ben_rq(i_ben_rq),
    .o_rq_vld(o_rq_vld), .o_req_vec_txn(o_req_vec_txn), .o_req_vec_dat(o_req_vec_dat),
    .o_txnid_rq(o_txnid_rq), .o_rnw_rq(o_rnw_rq), .o_addr_rq(o_addr_rq),
    .o_data_rq(o_data_rq), .o_ben_rq(o_ben_rq),
    .i_rs_vld(i_rs_vld), .i_txnid_rs(i_txnid_rs), .i_rnw_rs(i_rnw_rs),
    .i_err_rs(i_err_rs), .i_data_rs(i_data_rs),
    .o_rs_vld(o_rs_vld), .o_res_vec_txn(o_res_vec_txn), .o_res_vec_dat(o_res_vec_dat)
  );

  vxe_txnres_decoder u_rs_dec (
    .i_vec_txn(o_res_vec_txn), .i_vec_dat(o_res_vec_dat),
    .o_txnid(w_dtxnid_rs), .o_rnw(w_drnw_rs), .o_err(w_derr_rs), .o_data(w_ddata_rs)
  );

  typedef struct {
    logic        rq_vld;
    logic [5:0]  txnid_rq;
    logic        rnw_rq;
    logic [36:0] addr_rq;
    logic [63:0] data_rq;
    logic [7:0]  ben_rq;
    logic [43:0] exp_rq_txn;
    logic [71:0] exp_rq_dat;
    logic        rs_vld;
    logic [5:0]  txnid_rs;
    logic        rnw_rs;
    logic [1:0]  err_rs;
    logic [63:0] data_rs;
    logic [8:0]  exp_rs_txn;
  } vec_t;

  typedef struct packed {
    logic [43:0] txn;
    logic [71:0] dat;
    logic [5:0]  txnid;
    logic        rnw;
    logic [36:0] addr;
    logic [63:0] data;
    logic [7:0]  ben;
  } rq_exp_t;

  typedef struct packed {
    logic [8:0]  txn;
    logic [63:0] dat;
    logic [5:0]  txnid;
    logic        rnw;
    logic [1:0]  err;
  } rs_exp_t;

  vec_t    tbl[6];
  rq_exp_t q_rq[$];
  rs_exp_t q_rs[$];
  rq_exp_t m_rq;
  rs_exp_t m_rs;
  int      n_cmp = 0;
  int      n_fail = 0;

  task automatic cmp(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pop the scoreboard when the DUT presents a beat; held vectors compare to the model.
  task automatic check_cycle(input string tag);
    cmp({tag, ".rq_vld"}, 72'(o_rq_vld), 72'(q_rq.size() != 0));
    if (q_rq.size() != 0) m_rq = q_rq.pop_front();
    cmp({tag, ".req_txn"}, 72'(o_req_vec_txn), 72'(m_rq.txn));
    cmp({tag, ".req_dat"}, o_req_vec_dat, m_rq.dat);
    cmp({tag, ".dec_rq"}, {o_txnid_rq, o_rnw_rq, o_addr_rq, o_ben_rq},
        {m_rq.txnid, m_rq.rnw, m_rq.addr, m_rq.ben});
    cmp({tag, ".dec_rq_data"}, 72'(o_data_rq), 72'(m_rq.data));
    cmp({tag, ".rs_vld"}, 72'(o_rs_vld), 72'(q_rs.size() != 0));
    if (q_rs.size() != 0) m_rs = q_rs.pop_front();
    cmp({tag, ".res_txn"}, 72'(o_res_vec_txn), 72'(m_rs.txn));
    cmp({tag, ".res_dat"}, 72'(o_res_vec_dat), 72'(m_rs.dat));
    cmp({tag, ".dec_rs"}, 72'({w_dtxnid_rs, w_drnw_rs, w_derr_rs, w_ddata_rs}),
        72'({m_rs.txnid, m_rs.rnw, m_rs.err, m_rs.dat}));
  endtask

  task automatic drive(input vec_t v);
    rq_exp_t e;
    rs_exp_t s;
    i_rq_vld = v.rq_vld;  i_txnid_rq = v.txnid_rq; i_rnw_rq = v.rnw_rq;
    i_addr_rq = v.addr_rq; i_data_rq = v.data_rq;  i_ben_rq = v.ben_rq;
    i_rs_vld = v.rs_vld;  i_txnid_rs = v.txnid_rs; i_rnw_rs = v.rnw_rs;
    i_err_rs = v.err_rs;  i_data_rs = v.data_rs;
    if (v.rq_vld) begin
      e.txn = v.exp_rq_txn; e.dat = v.exp_rq_dat; e.txnid = v.txnid_rq;
      e.rnw = v.rnw_rq; e.addr = v.addr_rq; e.data = v.data_rq; e.ben = v.ben_rq;
      q_rq.push_back(e);
    end
    if (v.rs_vld) begin
      s.txn = v.exp_rs_txn; s.dat = v.data_rs; s.txnid = v.txnid_rs;
      s.rnw = v.rnw_rs; s.err = v.err_rs;
      q_rs.push_back(s);
    end
  endtask

  initial begin
    // Rows 0/1 carry hand-computed vectors; later rows pack with bench-side concatenation.
    tbl[0] = '{1'b1, 6'h3f, 1'b0, 37'h03_0303_0303, 64'hfefe_fafa_dada_dede, 8'h33,
               44'hFC3_0303_0303, 72'hfe_fefa_fada_dade_de33,
               1'b1, 6'h3f, 1'b0, 2'b11, 64'hfefe_fafa_dada_dede, 9'h1FB};
    tbl[1] = '{1'b1, 6'h2a, 1'b1, 37'h1f_1313_1313, 64'hdede_dada_fafa_fefe, 8'h11,
               44'hABF_1313_1313, 72'hde_deda_dafa_fafe_fe11,
               1'b1, 6'h2a, 1'b1, 2'b10, 64'hdede_dada_fafa_fefe, 9'h156};
    tbl[2] = '{1'b0, 6'h15, 1'b1, 37'h0a_5a5a_5a5a, 64'h1234_5678_9abc_def0, 8'ha5,
               44'h0, 72'h0, 1'b0, 6'h11, 1'b0, 2'b01, 64'h5555_aaaa_5555_aaaa, 9'h0};
    tbl[3] = '{1'b1, 6'h01, 1'b0, 37'h10_0000_0001, 64'h8000_0000_0000_0001, 8'h80,
               44'h0, 72'h0, 1'b0, 6'h3c, 1'b1, 2'b11, 64'hffff_0000_ffff_0000, 9'h0};
    tbl[4] = '{1'b0, 6'h22, 1'b1, 37'h00_dead_beef, 64'h0bad_f00d_0bad_f00d, 8'h0f,
               44'h0, 72'h0, 1'b1, 6'h00, 1'b0, 2'b00, 64'h0, 9'h0};
    tbl[5] = '{1'b1, 6'h3f, 1'b1, 37'h1f_ffff_ffff, 64'hffff_ffff_ffff_ffff, 8'hff,
               44'h0, 72'h0, 1'b1, 6'h15, 1'b1, 2'b01, 64'h0123_4567_89ab_cdef, 9'h0};
    for (int i = 2; i < 6; i++) begin
      tbl[i].exp_rq_txn = {tbl[i].txnid_rq, tbl[i].rnw_rq, tbl[i].addr_rq};
      tbl[i].exp_rq_dat = {tbl[i].data_rq, tbl[i].ben_rq};
      tbl[i].exp_rs_txn = {tbl[i].txnid_rs, tbl[i].rnw_rs, tbl[i].err_rs};
    end

    m_rq = '0;
    m_rs = '0;
    nrst = 1'b0;
    drive('{1'b0, 6'h0, 1'b0, 37'h0, 64'h0, 8'h0, 44'h0, 72'h0,
            1'b0, 6'h0, 1'b0, 2'b0, 64'h0, 9'h0});
    repeat (2) @(posedge clk);
    #1 check_cycle("reset");
    @(negedge clk) nrst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      drive(tbl[i]);
      @(posedge clk); #1;
      check_cycle($sformatf("row%0d", i));
    end

    // Mid-stream async reset: a beat is driven, then reset lands before the edge.
    drive(tbl[1]);
    #2 nrst = 1'b0;
    #1;
    q_rq.delete();
    q_rs.delete();
    m_rq = '0;
    m_rs = '0;
    check_cycle("async_rst");
    @(posedge clk); #1;
    check_cycle("rst_held");
    @(negedge clk) nrst = 1'b1;
    tbl[2].rq_vld = 1'b1;
    tbl[2].rs_vld = 1'b1;
    drive(tbl[2]);
    @(posedge clk); #1;
    check_cycle("post_rst");
    tbl[2].rq_vld = 1'b0;
    tbl[2].rs_vld = 1'b0;
    drive(tbl[2]);
    @(posedge clk); #1;
    check_cycle("post_rst_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
